// File: rtl/disp_sync_seq_ctrl_if.sv
// disp_sync_seq_ctrl_if: host control/config, generator feedback and run status of the sync sequencer
interface disp_sync_seq_ctrl_if #(parameter int CW = 12, parameter int FCW = 16);
   logic           i_start;
   logic           i_stop;
   logic [CW-1:0]  i_cfg_hres;
   logic [CW-1:0]  i_cfg_vres;
   logic [FCW-1:0] i_cfg_nframes;
   logic           i_vsync;
   logic           i_de;
   logic           o_gen_en;
   logic           o_busy;
   logic           o_frame_start;
   logic           o_done;
   logic [FCW-1:0] o_frame_cnt;
   logic [CW-1:0]  o_hres;
   logic [CW-1:0]  o_vres;
   logic           o_err_h;
   logic           o_err_v;
   logic           o_err_to;
   modport master (
      output i_start, i_stop, i_cfg_hres, i_cfg_vres, i_cfg_nframes, i_vsync, i_de,
      input  o_gen_en, o_busy, o_frame_start, o_done, o_frame_cnt, o_hres, o_vres,
             o_err_h, o_err_v, o_err_to
   );
   modport slave (
      input  i_start, i_stop, i_cfg_hres, i_cfg_vres, i_cfg_nframes, i_vsync, i_de,
      output o_gen_en, o_busy, o_frame_start, o_done, o_frame_cnt, o_hres, o_vres,
             o_err_h, o_err_v, o_err_to
   );
endinterface

// File: rtl/disp_sync_seq_ctrl.sv
// disp_sync_seq_ctrl: frame-aligned run/stop sequencer and geometry/liveness checker for the sync generator
module disp_sync_seq_ctrl #(
   parameter int CW      = 12,
   parameter int FCW     = 16,
   parameter int TIMEOUT = 1000000
) (
   input logic i_clk,
   input logic rst,
   disp_sync_seq_ctrl_if.slave bus
);
   localparam int TW = $clog2(TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE, START, RUN, STOP} state_t;
   state_t st, st_nx;
   logic vs_q, de_q, stop_req;
   logic gen_en, done, frame_start, err_h, err_v, err_to;
   logic gen_en_d, done_d, fs_d;
   logic [CW-1:0] de_cnt, line_cnt, hres, vres;
   logic [FCW-1:0] nframes, frame_cnt;
   logic [TW-1:0] to_cnt;
   logic active, vs_rise, de_fall, timeout, last_frame;
   assign active     = (st == START) || (st == RUN);
   assign vs_rise    = active & bus.i_vsync & ~vs_q;
   assign de_fall    = active & de_q & ~bus.i_de;
   assign timeout    = active & ~vs_rise & (to_cnt == TW'(TIMEOUT - 1));
   assign last_frame = (nframes != '0) && (frame_cnt + FCW'(1) == nframes);
   assign bus.o_gen_en      = gen_en;
   assign bus.o_busy        = st != IDLE;
   assign bus.o_frame_start = frame_start;
   assign bus.o_done        = done;
   assign bus.o_frame_cnt   = frame_cnt;
   assign bus.o_hres        = hres;
   assign bus.o_vres        = vres;
   assign bus.o_err_h       = err_h;
   assign bus.o_err_v       = err_v;
   assign bus.o_err_to      = err_to;
   // next state: stops only land on a frame boundary unless aborted from START or by timeout
   always_comb begin
      st_nx = st;
      case (st)
         IDLE:    st_nx = bus.i_start ? START : IDLE;
         START:   st_nx = (bus.i_stop || timeout) ? STOP : (vs_rise ? RUN : START);
         RUN:     st_nx = (timeout || (vs_rise && (stop_req || bus.i_stop || last_frame))) ? STOP : RUN;
         default: st_nx = IDLE;
      endcase
   end
   // next values of the registered control outputs
   always_comb begin
      gen_en_d = st_nx != IDLE;
      done_d   = st == STOP;
      fs_d     = vs_rise;
   end
   // state register, shadow geometry, frame/line/DE/timeout counters and sticky errors
   always_ff @(posedge i_clk) begin
      if (rst) begin
         st          <= IDLE;
         gen_en      <= 1'b0;
         done        <= 1'b0;
         frame_start <= 1'b0;
         vs_q        <= 1'b0;
         de_q        <= 1'b0;
         stop_req    <= 1'b0;
         err_h       <= 1'b0;
         err_v       <= 1'b0;
         err_to      <= 1'b0;
         de_cnt      <= '0;
         line_cnt    <= '0;
         hres        <= '0;
         vres        <= '0;
         nframes     <= '0;
         frame_cnt   <= '0;
         to_cnt      <= '0;
      end else begin
         st          <= st_nx;
         gen_en      <= gen_en_d;
         done        <= done_d;
         frame_start <= fs_d;
         vs_q        <= gen_en & bus.i_vsync;
         de_q        <= gen_en & bus.i_de;
         if (st == IDLE && bus.i_start) begin
            hres      <= bus.i_cfg_hres;
            vres      <= bus.i_cfg_vres;
            nframes   <= bus.i_cfg_nframes;
            frame_cnt <= '0;
            err_h     <= 1'b0;
            err_v     <= 1'b0;
            err_to    <= 1'b0;
            stop_req  <= 1'b0;
            to_cnt    <= '0;
            line_cnt  <= '0;
         end
         if (active) begin
            to_cnt <= vs_rise ? '0 : to_cnt + TW'(1);
            de_cnt <= bus.i_de ? ((de_cnt == '1) ? de_cnt : de_cnt + CW'(1)) : '0;
            if (de_fall) begin
               err_h    <= err_h | (de_cnt != hres);
               line_cnt <= (line_cnt == '1) ? line_cnt : line_cnt + CW'(1);
            end
            if (timeout) err_to <= 1'b1;
            if (st == RUN && bus.i_stop) stop_req <= 1'b1;
            if (vs_rise) begin
               line_cnt <= '0;
               if (st == RUN) begin
                  frame_cnt <= frame_cnt + FCW'(1);
                  err_v     <= err_v | (line_cnt != vres);
                  hres      <= bus.i_cfg_hres;
                  vres      <= bus.i_cfg_vres;
                  nframes   <= bus.i_cfg_nframes;
               end
            end
         end else begin
            de_cnt <= '0;
         end
      end
   end
endmodule

// File: tb/tb_disp_sync_seq_ctrl.sv
// tb_disp_sync_seq_ctrl: scoreboard bench with a 13x13 (4x4 active) sync generator model
module tb_disp_sync_seq_ctrl;
   localparam int CW = 12;
   localparam int FCW = 16;
   typedef struct packed {
      logic [FCW-1:0] cnt;
      logic eh;
      logic ev;
      logic eto;
   } done_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic vs_kill = 1'b0;
   logic [3:0] gh, gv;
   int checks = 0;
   int failures = 0;
   done_t done_q[$];
   logic [FCW-1:0] fs_q[$];
   done_t d;
   always #5 clk = ~clk;
   disp_sync_seq_ctrl_if #(.CW(CW), .FCW(FCW)) bus ();
   disp_sync_seq_ctrl #(.CW(CW), .FCW(FCW), .TIMEOUT(500)) dut (.i_clk(clk), .rst(rst), .bus(bus));
   // generator: held in reset while o_gen_en=0, DE on rows/cols 0..3, vsync on rows 8..9
   always_ff @(posedge clk) begin
      if (!bus.o_gen_en) begin
         gh <= '0;
         gv <= '0;
      end else begin
         gh <= (gh == 4'd12) ? 4'd0 : gh + 4'd1;
         if (gh == 4'd12) gv <= (gv == 4'd12) ? 4'd0 : gv + 4'd1;
      end
   end
   assign bus.i_de    = bus.o_gen_en && gh < 4'd4 && gv < 4'd4;
   assign bus.i_vsync = bus.o_gen_en && !vs_kill && (gv == 4'd8 || gv == 4'd9);
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask
   task automatic push_done(input int cnt, input logic eh, input logic ev, input logic eto);
      done_t t;
      t.cnt = FCW'(cnt);
      t.eh = eh;
      t.ev = ev;
      t.eto = eto;
      done_q.push_back(t);
   endtask
   task automatic push_fs(input int n);
      for (int i = 0; i < n; i++) fs_q.push_back(FCW'(i));
   endtask
   task automatic pulse_start();
      @(negedge clk) bus.i_start = 1'b1;
      @(negedge clk) bus.i_start = 1'b0;
   endtask
   task automatic pulse_stop();
      @(negedge clk) bus.i_stop = 1'b1;
      @(negedge clk) bus.i_stop = 1'b0;
   endtask
   task automatic wait_done(input string name);
      int n = 0;
      while (!bus.o_done && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk(name, bus.o_done, 1);
   endtask
   task automatic wait_fs(input int k, input string name);
      int n = 0;
      int seen = 0;
      while (seen < k && n < 2000) begin
         @(negedge clk);
         n++;
         if (bus.o_frame_start) seen++;
      end
      chk(name, seen, k);
   endtask
   // monitor: every frame_start / done pulse is matched against the next scoreboard entry
   always @(negedge clk) begin
      if (bus.o_frame_start) begin
         chk("fs_expected", fs_q.size() > 0, 1);
         if (fs_q.size() > 0) chk("fs_frame_cnt", bus.o_frame_cnt, fs_q.pop_front());
      end
      if (bus.o_done) begin
         chk("done_expected", done_q.size() > 0, 1);
         if (done_q.size() > 0) begin
            d = done_q.pop_front();
            chk("done_frame_cnt", bus.o_frame_cnt, d.cnt);
            chk("done_err_genen_busy", {bus.o_err_h, bus.o_err_v, bus.o_err_to, bus.o_gen_en, bus.o_busy},
                {d.eh, d.ev, d.eto, 2'b00});
         end
      end
   end
   initial begin
      bus.i_start = 1'b0;
      bus.i_stop = 1'b0;
      bus.i_cfg_hres = 12'd4;
      bus.i_cfg_vres = 12'd4;
      bus.i_cfg_nframes = 16'd3;
      repeat (3) @(negedge clk);
      chk("reset_state", {bus.o_gen_en, bus.o_busy, bus.o_frame_start, bus.o_done, bus.o_frame_cnt,
          bus.o_hres, bus.o_vres, bus.o_err_h, bus.o_err_v, bus.o_err_to}, 0);
      rst = 1'b0;
      // 1: three-frame run
      push_fs(4);
      push_done(3, 0, 0, 0);
      pulse_start();
      chk("t1_gen_en", bus.o_gen_en, 1);
      chk("t1_busy", bus.o_busy, 1);
      chk("t1_shadow", {bus.o_hres, bus.o_vres}, {12'd4, 12'd4});
      wait_done("t1_done_seen");
      @(negedge clk);
      chk("t1_done_one_cycle", {bus.o_done, bus.o_gen_en, bus.o_busy}, 0);
      // 2: continuous, stop mid frame 2
      bus.i_cfg_nframes = 16'd0;
      push_fs(3);
      push_done(2, 0, 0, 0);
      pulse_start();
      wait_fs(2, "t2_two_frame_starts");
      repeat (60) @(negedge clk);
      pulse_stop();
      chk("t2_still_running", {bus.o_busy, bus.o_gen_en, bus.o_frame_cnt}, {2'b11, 16'd1});
      wait_done("t2_done_seen");
      // 3: geometry mismatch
      bus.i_cfg_hres = 12'd5;
      bus.i_cfg_vres = 12'd3;
      bus.i_cfg_nframes = 16'd2;
      push_fs(3);
      push_done(2, 1, 1, 0);
      pulse_start();
      repeat (10) @(negedge clk);
      chk("t3_err_h_early", {bus.o_err_h, bus.o_err_v}, 2'b10);
      wait_done("t3_done_seen");
      bus.i_cfg_hres = 12'd4;
      bus.i_cfg_vres = 12'd4;
      // 4: vsync stuck low -> timeout
      bus.i_cfg_nframes = 16'd0;
      vs_kill = 1'b1;
      push_done(0, 0, 0, 1);
      pulse_start();
      repeat (499) @(negedge clk);
      chk("t4_no_timeout_499", {bus.o_err_to, bus.o_busy}, 2'b01);
      @(negedge clk);
      chk("t4_timeout_500", bus.o_err_to, 1);
      wait_done("t4_done_seen");
      vs_kill = 1'b0;
      // 5: shadow update on frame boundary, start while busy ignored
      push_fs(3);
      push_done(2, 1, 0, 0);
      pulse_start();
      wait_fs(1, "t5_first_frame_start");
      repeat (50) @(negedge clk);
      bus.i_cfg_hres = 12'd6;
      repeat (118) @(negedge clk);
      chk("t5_hres_held", bus.o_hres, 4);
      @(negedge clk);
      chk("t5_hres_updated", {bus.o_hres, bus.o_frame_start}, {12'd6, 1'b1});
      pulse_start();
      chk("t5_start_ignored", {bus.o_busy, bus.o_frame_cnt}, {1'b1, 16'd1});
      pulse_stop();
      wait_done("t5_done_seen");
      bus.i_cfg_hres = 12'd4;
      // 6: reset mid-run, then a normal single-frame run
      push_fs(1);
      pulse_start();
      wait_fs(1, "t6_first_frame_start");
      repeat (20) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t6_reset_state", {bus.o_gen_en, bus.o_busy, bus.o_frame_start, bus.o_done, bus.o_frame_cnt,
          bus.o_hres, bus.o_vres, bus.o_err_h, bus.o_err_v, bus.o_err_to}, 0);
      bus.i_cfg_nframes = 16'd1;
      push_fs(2);
      push_done(1, 0, 0, 0);
      pulse_start();
      wait_done("t6_done_seen");
      repeat (5) @(negedge clk);
      chk("fs_queue_drained", fs_q.size(), 0);
      chk("done_queue_drained", done_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
